crc_feeder: RTL and testbench
=============================

# crc_feeder

Bus-master front end for the CRC slave. Accepts 32-bit words on a valid/ready stream, buffers them in a small FIFO, and drives each word into the CRC slave's register interface. It then reads back the CRC remainder and presents it, paired with the source word, on an output valid/ready stream. It sits directly upstream of the CRC slave and replaces the hand-driven bus stimulus used during slave bring-up.

## Interface
Parameters:
- DATA_WIDTH, 32, stream word and bus data width
- CRC_WIDTH, 3, remainder width taken from read data bits [CRC_WIDTH-1:0]
- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2)
- TIMEOUT_CYCLES, 64, WAIT_VALID limit (used only with timeout feature)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_data  in  DATA_WIDTH  input word
- in_ready  out  1  FIFO not full
- out_valid  out  1  result valid
- out_data  out  DATA_WIDTH  word the CRC belongs to
- out_crc  out  CRC_WIDTH  CRC remainder
- out_err  out  1  result invalid (timeout); constant 0 without feature
- out_ready  in  1  consumer accepts result
- m_addr  out  2  slave register address
- m_cs, m_write, m_read  out  1 each  bus strobes
- m_write_data  out  DATA_WIDTH  word to slave
- m_read_data  in  DATA_WIDTH  slave read data
- m_read_data_valid  in  1  slave read data valid
- m_wait_req  in  1  slave stall
- word_count  out  16  results delivered, wraps 0xFFFF→0

## Operation
- Slave map is fixed: ADDR_START=2'b01 (write data + start); ADDR_RESULT=2'b10 (read remainder).
- FSM states and transitions:
  - IDLE→LOAD when FIFO is non-empty. LOAD pops one word into the data register.
  - LOAD→WRITE. WRITE drives m_cs=1, m_write=1, m_addr=ADDR_START, m_write_data=word.
  - WRITE→READ on the first cycle with m_wait_req=0. Strobes are held unchanged while stalled.
  - READ drives m_cs=1, m_read=1, m_addr=ADDR_RESULT, and leaves on m_wait_req=0 to WAIT_VALID.
  - WAIT_VALID: bus strobes 0. On m_read_data_valid=1, captures m_read_data[CRC_WIDTH-1:0]→out_crc and goes to OUTPUT.
  - OUTPUT: out_valid=1, out_data/out_crc stable. On out_ready=1, returns to IDLE and increments word_count.
- m_read_data_valid outside WAIT_VALID is ignored.
- m_cs is 1 only in WRITE/READ. m_read and m_write are never both 1.
- FIFO push and pop in the same cycle are allowed when full: in_ready reflects pre-pop occupancy, so a full FIFO still deasserts in_ready that cycle.
- Words leave in arrival order. No word is dropped or duplicated.

## Timing
- Reset values: in_ready=0 during reset and 1 after. All other outputs are 0; FIFO empty; FSM IDLE.
- Reset mid-operation aborts any bus transfer immediately (asynchronous) and discards FIFO contents.
- Zero-stall path: in handshake at T0 → LOAD T1 → WRITE T2 → READ T3 → WAIT_VALID T4. For read_data_valid at Tv ≥ T4, out_valid is asserted at Tv+1.
- Throughput is one word per transaction; no overlap between consecutive words.

## Configuration
- CRC_FEEDER_TIMEOUT_EN defined:
  - A counter runs in WAIT_VALID.
  - After TIMEOUT_CYCLES cycles without read_data_valid, the FSM enters OUTPUT with out_err=1 and out_crc=0.
  - word_count still increments.
- Undefined: no counter; WAIT_VALID waits indefinitely; out_err is tied 0.

## Structure
- crc_feeder_pkg holds:
  - the state enum (IDLE, LOAD, WRITE, READ, WAIT_VALID, OUTPUT)
  - ADDR_START and ADDR_RESULT
  - the default widths
- One sub-module, crc_feeder_fifo: synchronous FIFO with full/empty flags, parameterised on width and depth, same clk/reset_n.

## Test plan
- Single word 32'h0089CADE, m_wait_req=0, slave model returns valid 2 cycles after read → exactly one write at addr 01 with data 0089CADE, one read at addr 10. Then out_valid with out_data=0089CADE, out_crc equal to the model remainder (poly 3'h3), and word_count=1.
- m_wait_req held 1 for 3 cycles during WRITE and again during READ → strobes, address and data are stable across stalls; exactly one transfer of each kind.
- Push 6 words back-to-back with out_ready=1 → in_ready drops after FIFO_DEPTH+1 accepted. All 6 results come out in order and word_count=6.
- out_ready=0 for 10 cycles in OUTPUT → out_valid, out_data and out_crc stay stable; no new bus transfer starts.
- Assert reset_n=0 while in READ with m_wait_req=1 → m_cs and m_read go to 0 immediately. After release, the FIFO is empty and word_count=0.
- With CRC_FEEDER_TIMEOUT_EN, slave never asserts read_data_valid → out_valid with out_err=1 after 64 WAIT_VALID cycles, then normal operation resumes on the next word.

Source files
------------

// File: rtl/crc_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_feeder_pkg
// Description : Shared types and constants for the CRC slave bus feeder:
//               FSM state encoding, slave register map, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package crc_feeder_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_CRC_WIDTH      = 3;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // CRC slave register map
    localparam logic [1:0] ADDR_START  = 2'b01;
    localparam logic [1:0] ADDR_RESULT = 2'b10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        WRITE      = 3'd2,
        READ       = 3'd3,
        WAIT_VALID = 3'd4,
        OUTPUT     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/crc_feeder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : crc_feeder_fifo
// Description : Synchronous FIFO with full/empty flags. The head entry is
//               presented combinationally on o_rdata; DEPTH must be a power
//               of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_feeder_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int               c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0]    c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr];

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/crc_feeder.sv
`default_nettype none
// ============================================================================
// Module      : crc_feeder
// Description : Bus-master front end for the CRC slave. Buffers input words,
//               writes each to the slave start register, reads back the
//               remainder and emits {word, crc} on an output stream.
//               Optional macro CRC_FEEDER_TIMEOUT_EN: bounded wait for read
//               data, reporting out_err=1 / out_crc=0 on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_feeder
    import crc_feeder_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int CRC_WIDTH      = DEF_CRC_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CRC_WIDTH-1:0]  out_crc,
    output logic                  out_err,
    input  logic                  out_ready,
    output logic [1:0]            m_addr,
    output logic                  m_cs,
    output logic                  m_write,
    output logic                  m_read,
    output logic [DATA_WIDTH-1:0] m_write_data,
    input  logic [DATA_WIDTH-1:0] m_read_data,
    input  logic                  m_read_data_valid,
    input  logic                  m_wait_req,
    output logic [15:0]           word_count
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1 || CRC_WIDTH > DATA_WIDTH) begin : g_bad_params
        $error("crc_feeder: illegal parameter combination");
    end

    state_t                r_state;
    state_t                w_next;
    logic                  r_alive;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CRC_WIDTH-1:0]  r_crc;
    logic [15:0]           r_word_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_rdata;
    logic                  w_unused_rdata;

    // in_ready stays low until the first clock after reset release.
    assign in_ready       = r_alive && !w_fifo_full;
    assign w_push         = in_valid && in_ready;
    assign w_pop          = (r_state == LOAD);
    assign out_data       = r_data;
    assign out_crc        = r_crc;
    assign word_count     = r_word_count;
    assign w_unused_rdata = ^m_read_data[DATA_WIDTH-1:CRC_WIDTH];

    crc_feeder_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef CRC_FEEDER_TIMEOUT_EN
    localparam int                c_tw      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tw-1:0]   c_to_last = c_tw'(TIMEOUT_CYCLES - 1);

    logic [c_tw-1:0] r_to_cnt;
    logic            r_err;
    logic            w_timeout;

    assign out_err = r_err;

    // Counts consecutive WAIT_VALID cycles; cleared in every other state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state == WAIT_VALID) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    assign out_err = 1'b0;
`endif

    // Reset-release marker and FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alive <= 1'b0;
            r_state <= IDLE;
        end else begin
            r_alive <= 1'b1;
            r_state <= w_next;
        end
    end

    // Next-state and bus/stream strobes; strobes depend on state only.
    always_comb begin
        w_next       = r_state;
        m_cs         = 1'b0;
        m_write      = 1'b0;
        m_read       = 1'b0;
        m_addr       = 2'b00;
        m_write_data = '0;
        out_valid    = 1'b0;
        w_capture    = 1'b0;
`ifdef CRC_FEEDER_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // A word arriving this cycle is at the FIFO head by LOAD.
                if (!w_fifo_empty || w_push) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_next = WRITE;
            end
            WRITE: begin
                m_cs         = 1'b1;
                m_write      = 1'b1;
                m_addr       = ADDR_START;
                m_write_data = r_data;
                if (!m_wait_req) begin
                    w_next = READ;
                end
            end
            READ: begin
                m_cs   = 1'b1;
                m_read = 1'b1;
                m_addr = ADDR_RESULT;
                if (!m_wait_req) begin
                    w_next = WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                if (m_read_data_valid) begin
                    w_capture = 1'b1;
                    w_next    = OUTPUT;
                end
`ifdef CRC_FEEDER_TIMEOUT_EN
                else if (r_to_cnt == c_to_last) begin
                    w_timeout = 1'b1;
                    w_next    = OUTPUT;
                end
`endif
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Word, remainder and delivered-result counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data       <= '0;
            r_crc        <= '0;
            r_word_count <= '0;
`ifdef CRC_FEEDER_TIMEOUT_EN
            r_err        <= 1'b0;
`endif
        end else begin
            if (r_state == LOAD) begin
                r_data <= w_fifo_rdata;
            end
            if (w_capture) begin
                r_crc <= m_read_data[CRC_WIDTH-1:0];
`ifdef CRC_FEEDER_TIMEOUT_EN
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_crc <= '0;
                r_err <= 1'b1;
`endif
            end
            if (r_state == OUTPUT && out_ready) begin
                r_word_count <= r_word_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_feeder
// Description : Self-checking bench for crc_feeder: behavioural CRC slave,
//               randomized stimulus, queue scoreboard with a separate output
//               monitor. Honours CRC_FEEDER_TIMEOUT_EN for the timeout case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_feeder;

    localparam int DW    = 32;
    localparam int CW    = 3;
    localparam int DEPTH = 4;
    localparam int TO    = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_crc;
    logic          out_err;
    logic          out_ready = 1'b0;
    logic [1:0]    m_addr;
    logic          m_cs, m_write, m_read;
    logic [DW-1:0] m_write_data;
    logic [DW-1:0] m_read_data = '0;
    logic          m_read_data_valid = 1'b0;
    logic          m_wait_req = 1'b0;
    logic [15:0]   word_count;

    crc_feeder #(
        .DATA_WIDTH     (DW),
        .CRC_WIDTH      (CW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_crc           (out_crc),
        .out_err           (out_err),
        .out_ready         (out_ready),
        .m_addr            (m_addr),
        .m_cs              (m_cs),
        .m_write           (m_write),
        .m_read            (m_read),
        .m_write_data      (m_write_data),
        .m_read_data       (m_read_data),
        .m_read_data_valid (m_read_data_valid),
        .m_wait_req        (m_wait_req),
        .word_count        (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] crc;
        logic          err;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // test controls
    int stall_w = 0, stall_r = 0, rd_delay = 2;
    bit rand_stall = 0;
    int ready_mode = 1;
    bit expect_to = 0;
    // observations
    int delivered = 0;
    int wr_cnt = 0, rd_cnt = 0;
    int wr_cyc = 0, rd_cyc = 0, vld_cyc = 0, out_cyc = -1, t0_cyc = 0;
    logic [DW-1:0] last_wr_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Remainder of word(x)*x^3 divided by x^3+x+1 (poly 3'h3), MSB first.
    function automatic logic [CW-1:0] ref_crc(input logic [DW-1:0] w);
        logic [DW+CW-1:0] r;
        r = {w, {CW{1'b0}}};
        for (int i = DW + CW - 1; i >= CW; i--) begin
            if (r[i]) r[i -: CW+1] = r[i -: CW+1] ^ 4'b1011;
        end
        return r[CW-1:0];
    endfunction

    // Behavioural CRC slave: stalls, records transfers, returns remainder.
    initial begin : slave
        bit            in_xfer;
        int            stall_left, cd;
        logic [1:0]    s_addr;
        logic [DW-1:0] s_data;
        logic          s_we;
        logic [DW-1:0] word;
        in_xfer = 0; stall_left = 0; cd = 0; s_addr = '0; s_data = '0; s_we = 0; word = '0;
        forever begin
            @(negedge clk);
            m_read_data_valid = 1'b0;
            m_read_data       = $urandom;
            if (!reset_n) begin
                in_xfer = 0; stall_left = 0; cd = 0; m_wait_req = 1'b0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        m_read_data_valid     = 1'b1;
                        m_read_data[CW-1:0]   = ref_crc(word);
                        vld_cyc               = cyc;
                    end
                end
                if (m_cs) begin
                    chk("rw_exclusive", {m_read, m_write}, (m_write ? 2'b01 : 2'b10));
                    if (!in_xfer) begin
                        in_xfer = 1; s_addr = m_addr; s_data = m_write_data; s_we = m_write;
                        stall_left = rand_stall ? $urandom_range(0, 3) : (m_write ? stall_w : stall_r);
                    end else begin
                        chk("stall_addr", m_addr, s_addr);
                        chk("stall_wdata", m_write_data, s_data);
                        chk("stall_we", m_write, s_we);
                    end
                    if (stall_left > 0) begin
                        m_wait_req = 1'b1;
                        stall_left--;
                        if (m_write && rand_stall && ($urandom_range(0, 1) == 1)) begin
                            m_read_data_valid = 1'b1;   // stray pulse, must be ignored
                        end
                    end else begin
                        m_wait_req = 1'b0;
                        in_xfer    = 0;
                        if (m_write) begin
                            wr_cnt++; wr_cyc = cyc; word = m_write_data; last_wr_data = m_write_data;
                            chk("write_addr", m_addr, 2'b01);
                        end else begin
                            rd_cnt++; rd_cyc = cyc;
                            chk("read_addr", m_addr, 2'b10);
                            cd = rand_stall ? $urandom_range(1, 4) : rd_delay;
                        end
                    end
                end else begin
                    m_wait_req = 1'b0;
                end
            end
        end
    end

    // Output monitor: owns out_ready, pops and compares on each handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                out_ready = 1'b0;
            end else begin
                case (ready_mode)
                    0:       out_ready = 1'b0;
                    1:       out_ready = 1'b1;
                    default: out_ready = ($urandom_range(0, 1) == 1);
                endcase
                if (out_valid && out_cyc < 0) out_cyc = cyc;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 64'd0, 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_crc", out_crc, e.crc);
                        chk("out_err", out_err, e.err);
                        chk("word_count_at_out", word_count, 16'(delivered));
                    end
                    delivered++;
                end
            end
        end
    end

    // Offer one word; called at a falling edge, returns at a falling edge.
    task automatic push_word(input logic [DW-1:0] w, output int waits);
        exp_t e;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && waits <= 200) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
        end else begin
            e.data = w;
            e.crc  = expect_to ? '0 : ref_crc(w);
            e.err  = expect_to;
            exp_q.push_back(e);
            t0_cyc = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && !out_valid && !m_cs) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

    initial begin : main
        int            w, first_block, wr0, rd0, d0, n;
        logic [DW-1:0] h_data;
        logic [CW-1:0] h_crc;
        bit            saw_act;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bus", {m_cs, m_write, m_read, m_addr}, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_out_fields", {out_data, out_crc, out_err}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        // single word, zero stall, valid two cycles after read
        out_cyc = -1;
        push_word(32'h0089CADE, w);
        wait_idle();
        chk("single_wr_cnt", wr_cnt, 1);
        chk("single_rd_cnt", rd_cnt, 1);
        chk("single_wr_data", last_wr_data, 32'h0089CADE);
        chk("single_wr_cyc", wr_cyc, t0_cyc + 2);
        chk("single_rd_cyc", rd_cyc, t0_cyc + 3);
        chk("single_out_cyc", out_cyc, vld_cyc + 1);
        chk("single_word_count", word_count, 1);

        // three stall cycles on both write and read
        wr0 = wr_cnt; rd0 = rd_cnt;
        stall_w = 3; stall_r = 3;
        push_word($urandom, w);
        wait_idle();
        chk("stall_wr_cnt", wr_cnt, wr0 + 1);
        chk("stall_rd_cnt", rd_cnt, rd0 + 1);
        chk("stall_wr_cyc", wr_cyc, t0_cyc + 5);
        chk("stall_rd_cyc", rd_cyc, t0_cyc + 9);
        stall_w = 0; stall_r = 0;

        // six back-to-back words
        d0 = delivered; first_block = -1; rd_delay = 1;
        for (int i = 0; i < 6; i++) begin
            push_word($urandom, w);
            if (w > 0 && first_block < 0) first_block = i;
        end
        chk("burst_accept_before_full", first_block, DEPTH + 1);
        wait_idle();
        chk("burst_delivered", delivered - d0, 6);
        chk("burst_word_count", word_count, 16'(delivered));

        // consumer stalls for 10 cycles with another word queued
        ready_mode = 0; rd_delay = 2;
        push_word($urandom, w);
        push_word($urandom, w);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("hold_out_valid_seen", out_valid, 1);
        h_data = out_data; h_crc = out_crc;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", out_data, h_data);
            chk("hold_out_crc", out_crc, h_crc);
            chk("hold_no_bus", m_cs, 0);
        end
        ready_mode = 1;
        wait_idle();

        // randomized traffic
        rand_stall = 1; ready_mode = 2;
        for (int i = 0; i < 30; i++) begin
            push_word($urandom, w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        rand_stall = 0; ready_mode = 1;
        chk("rand_word_count", word_count, 16'(delivered));

`ifdef CRC_FEEDER_TIMEOUT_EN
        // slave never answers: error result after the timeout, then recovery
        rd_delay = 0; expect_to = 1; out_cyc = -1;
        push_word($urandom, w);
        wait_idle();
        chk("timeout_out_cyc", out_cyc, rd_cyc + TO + 1);
        rd_delay = 2; expect_to = 0;
        push_word($urandom, w);
        wait_idle();
        chk("timeout_word_count", word_count, 16'(delivered));
`endif

        // reset while a stalled read is in progress, FIFO holding words
        stall_r = 50;
        push_word($urandom, w);
        push_word($urandom, w);
        push_word($urandom, w);
        n = 0;
        while (!m_read && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("pre_rst_read_stalled", {m_cs, m_read, m_wait_req}, 3'b111);
        reset_n = 1'b0;
        #1;
        chk("rst_async_cs", m_cs, 0);
        chk("rst_async_read", m_read, 0);
        chk("rst_async_in_ready", in_ready, 0);
        exp_q.delete();
        delivered = 0;
        stall_r = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        saw_act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_cs || out_valid) saw_act = 1;
        end
        chk("post_rst_fifo_empty", saw_act, 0);
        chk("post_rst_word_count", word_count, 0);
        chk("post_rst_in_ready", in_ready, 1);
        push_word($urandom, w);
        wait_idle();
        chk("post_rst_single", word_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
